// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// program_loader_pkg : shared FSM state encoding and default geometry
// Revision 1.0
// ============================================================================
package program_loader_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_word_pack.sv
`default_nettype none
// ============================================================================
// loader_word_pack : low-byte latch plus registered 16-bit word write port
// Revision 1.0
// ============================================================================
module loader_word_pack #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lo_en,
    input  logic              hi_en,
    input  logic [7:0]        data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       wdata
);

    logic [7:0] lo_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_byte <= '0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            if (lo_en) begin
                lo_byte <= data_in;
            end
            // Strobe is a single-cycle pulse following the high byte
            we <= hi_en;
            if (hi_en) begin
                addr  <= addr_in;
                wdata <= {data_in, lo_byte};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : byte-stream loader into instruction memory, holds the core
// in reset until done. Optional checksum byte via LOADER_CSUM_EN.  Revision 1.0
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] IDX_ONE = 1;

    state_t            state;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   len_words;
    logic [ADDR_W:0]   index;
    logic              accept;
    logic              restart;
    logic              len_ok;
    logic              last_word;
    logic [15:0]       len_full;

    assign in_ready   = (state == ST_LEN_LO)  || (state == ST_LEN_HI) ||
                        (state == ST_DATA_LO) || (state == ST_DATA_HI) ||
                        (state == ST_CSUM);
    assign done       = (state == ST_DONE);
    assign core_rst_n = (state == ST_DONE);
    assign error      = (state == ST_ERR);

    assign accept    = in_valid && in_ready;
    assign restart   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_full  = {in_data, len_lo};
    assign len_ok    = (len_full != 16'd0) && (len_full <= 16'(DEPTH));
    assign last_word = ((index + IDX_ONE) == len_words);

`ifdef LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (restart) begin
            csum <= '0;
        end else if (accept && (state != ST_CSUM)) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_lo    <= '0;
            len_words <= '0;
            index     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state <= ST_LEN_LO;
                        index <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_words <= len_full[ADDR_W:0];
                        state     <= len_ok ? ST_DATA_LO : ST_ERR;
                    end
                end
                ST_DATA_LO: begin
                    if (accept) begin
                        state <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (accept) begin
                        index <= index + IDX_ONE;
                        if (!last_word) begin
                            state <= ST_DATA_LO;
                        end else begin
`ifdef LOADER_CSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef LOADER_CSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        state <= (in_data == csum) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    loader_word_pack #(
        .ADDR_W (ADDR_W)
    ) u_word_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .lo_en   (accept && (state == ST_DATA_LO)),
        .hi_en   (accept && (state == ST_DATA_HI)),
        .data_in (in_data),
        .addr_in (index[ADDR_W-1:0]),
        .we      (imem_we),
        .addr    (imem_addr),
        .wdata   (imem_wdata)
    );

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 16: instruction-memory depth in 16-bit words.
REQ-002 Parameter ADDR_W, default 4: instruction-memory address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  16  instruction word to write.
REQ-012 core_rst_n  output  1  active-low hold-reset to the downstream 16-bit core.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load aborted on a bad length or checksum.

Function
REQ-015 A byte SHALL transfer only on a cycle where in_valid and in_ready are both high; in_data SHALL be ignored otherwise.
REQ-016 The stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N), then N words, each sent low byte first; the checksum byte follows when enabled.
REQ-017 The FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE and ERR.
- IDLE -> LEN_LO on start.
- LEN_LO -> LEN_HI on an accepted byte.
- LEN_HI -> DATA_LO on an accepted byte when 1 <= N <= DEPTH; otherwise -> ERR.
REQ-018 DATA_LO -> DATA_HI on an accepted byte, which SHALL be latched as the low byte.
REQ-019 On a byte accepted in DATA_HI, the loader SHALL:
- assert imem_we for exactly the next cycle, with imem_wdata = {high byte, low byte} and imem_addr = word index;
- increment the index;
- go to DATA_LO if words remain, otherwise to CSUM (when enabled) or DONE.
REQ-020 The word index SHALL start at 0 for every load and SHALL never wrap; the length check guarantees the index stays below DEPTH.
REQ-021 in_ready SHALL be high in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM, and low in IDLE, DONE and ERR.
REQ-022 While imem_we is high, in_ready SHALL still be asserted, giving zero-bubble back-to-back bytes.
REQ-023 In DONE, done and core_rst_n SHALL be 1; in all other states both SHALL be 0.
REQ-024 In ERR, error SHALL be 1; it SHALL clear on the next start.
REQ-025 start SHALL be ignored in LEN_LO through CSUM.
REQ-026 start in DONE or ERR SHALL restart at LEN_LO, dropping core_rst_n to 0 in the cycle after start.
REQ-027 If start and in_valid occur in the same cycle in IDLE, DONE or ERR, no byte SHALL be consumed, because in_ready is low.

Reset
REQ-028 While rst_n is low, the FSM SHALL be in IDLE and all outputs SHALL be 0, including core_rst_n; the word index, byte latch and checksum SHALL be 0.
REQ-029 Reset asserted mid-load SHALL abandon the load immediately; words already written SHALL remain in memory, and done SHALL not assert.

Configuration
REQ-030 With LOADER_CSUM_EN defined:
- the loader SHALL keep a running XOR of all LEN and DATA bytes;
- the byte accepted in CSUM SHALL be compared to that XOR, going to DONE on a match and to ERR on a mismatch.
REQ-031 Without LOADER_CSUM_EN, the CSUM state, the XOR register and the comparison SHALL be absent, and the final DATA_HI byte SHALL go directly to DONE.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (3-bit constants) and the default DEPTH and ADDR_W constants.
REQ-033 The byte-to-word assembler (low-byte latch plus the word output register) SHALL be one sub-module, loader_word_pack; the FSM stays in program_loader.

Verification
REQ-034 Reset, then start, then bytes 02 00 34 12 78 56 -> writes addr0=0x1234 and addr1=0x5678, each imem_we exactly one cycle, then done=1 and core_rst_n=1.
REQ-035 Start, then LEN bytes 00 00 (N=0) -> error=1, no imem_we, core_rst_n stays 0; also LEN 11 00 with DEPTH=16 -> error=1.
REQ-036 in_valid toggled 1-0-1 per cycle through a 3-word load -> every byte is accepted only on a valid&ready cycle, and the memory contents are exact.
REQ-037 rst_n pulled low after the first word is written -> all outputs 0 at once; a following start with a full 1-word stream -> done=1.
REQ-038 LOADER_CSUM_EN build: stream 01 00 CD AB with checksum 67 (=01^00^CD^AB) -> done=1; checksum 00 -> error=1 and core_rst_n=0.
REQ-039 start pulsed in DONE -> core_rst_n=0 on the next cycle and the loader accepts a new LEN_LO.
